// File: rtl/sr_pulse_driver_if.sv
// Request/drive bundle between a requester and sr_pulse_driver.
// The requester also supplies q_fb, the latch output fed back from the board.
interface sr_pulse_driver_if;
    logic set_req;
    logic clr_req;
    logic req_ready;
    logic S;
    logic R;
    logic q_fb;
    logic done;
    logic err;

    modport slave (
        input  set_req, clr_req, q_fb,
        output req_ready, S, R, done, err
    );

    modport master (
        output set_req, clr_req, q_fb,
        input  req_ready, S, R, done, err
    );
endinterface

// File: rtl/sr_pulse_driver.sv
// Sequences guarded, fixed-width S/R pulses into a NOR SR latch, one command at a time.
// Define SR_PULSE_VERIFY_EN to synchronize q_fb and check the latch state after each pulse.
module sr_pulse_driver #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 1
) (
    input logic              clk,
    input logic              rst_n,
    sr_pulse_driver_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        PULSE = 2'd2,
        CHECK = 2'd3
    } state_t;

    // Counters are preloaded with width-1 so that reaching 0 ends the phase.
    localparam logic [3:0] GAP_LD = 4'(GAP_W - 1);
    localparam logic [3:0] PLS_LD = 4'(PULSE_W - 1);

    state_t     r_state;
    logic       r_cmd;
    logic       r_ready;
    logic       r_s;
    logic       r_r;
    logic       r_done;
    logic       r_err;
    logic [3:0] r_gap_cnt;
    logic [3:0] r_pls_cnt;

    logic w_accept;
    logic w_conflict;
    logic w_fb_bad;

    assign w_accept   = r_ready & (bus.set_req ^ bus.clr_req);
    assign w_conflict = r_ready & bus.set_req & bus.clr_req;

`ifdef SR_PULSE_VERIFY_EN
    logic r_q_s1;
    logic r_q_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_s1 <= 1'b0;
            r_q_s2 <= 1'b0;
        end else begin
            r_q_s1 <= bus.q_fb;
            r_q_s2 <= r_q_s1;
        end
    end

    assign w_fb_bad = (r_q_s2 != r_cmd);
`else
    assign w_fb_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cmd     <= 1'b0;
            r_ready   <= 1'b0;
            r_s       <= 1'b0;
            r_r       <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_gap_cnt <= 4'd0;
            r_pls_cnt <= 4'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cmd     <= bus.set_req;
                        r_gap_cnt <= GAP_LD;
                        r_ready   <= 1'b0;
                        r_state   <= GAP;
                    end else begin
                        r_ready <= 1'b1;
                        r_err   <= w_conflict;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == 4'd0) begin
                        r_pls_cnt <= PLS_LD;
                        r_s       <= r_cmd;
                        r_r       <= ~r_cmd;
                        r_state   <= PULSE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                PULSE: begin
                    if (r_pls_cnt == 4'd0) begin
                        r_s     <= 1'b0;
                        r_r     <= 1'b0;
                        r_state <= CHECK;
                    end else begin
                        r_pls_cnt <= r_pls_cnt - 4'd1;
                    end
                end
                CHECK: begin
                    r_done  <= 1'b1;
                    r_err   <= w_fb_bad;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.S         = r_s;
    assign bus.R         = r_r;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_sr_pulse_driver.sv
// Bench for sr_pulse_driver: default instance checked cycle-by-cycle against a timing model,
// plus a PULSE_W=15/GAP_W=15 instance for the long-latency case.
module tb_sr_pulse_driver;
    localparam int G  = 1;
    localparam int P  = 2;
    localparam int L  = G + P + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sr_pulse_driver_if bus ();
    sr_pulse_driver_if bus2 ();

    sr_pulse_driver #(.PULSE_W(P), .GAP_W(G)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    sr_pulse_driver #(.PULSE_W(15), .GAP_W(15)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    // Behavioural NOR latches on the S/R drives.
    logic lq = 1'b0, lq2 = 1'b0, fb_sel = 1'b1, fb_force = 1'b0;
    always @(bus.S or bus.R)   if (bus.S) lq = 1'b1;  else if (bus.R) lq = 1'b0;
    always @(bus2.S or bus2.R) if (bus2.S) lq2 = 1'b1; else if (bus2.R) lq2 = 1'b0;
    assign bus.q_fb  = fb_sel ? lq : fb_force;
    assign bus2.q_fb = lq2;

    logic [4:0] obs;
    assign obs = {bus.req_ready, bus.S, bus.R, bus.done, bus.err};

    int     errors = 0;
    int     checks = 0;
    longint n      = 0;
    longint m_acc  = -1000;
    logic   m_cmd  = 1'b0;

    // Timing model: all outputs follow from the edge index relative to the last accept.
    task automatic model_edge(output logic [4:0] e);
        logic   rb, s, c;
        longint j;
        s  = bus.set_req;
        c  = bus.clr_req;
        n++;
        rb = (n - 1 - m_acc) >= L;
        e[0] = rb & s & c;
        if (rb && (s ^ c)) begin
            m_acc = n;
            m_cmd = s;
        end
        j = n - m_acc;
        e[4] = (j >= L);
        e[3] = m_cmd && (j >= G) && (j < G + P);
        e[2] = !m_cmd && (j >= G) && (j < G + P);
        e[1] = (j == L);
    endtask

    task automatic drive(input logic s, input logic c);
        bus.set_req = s;
        bus.clr_req = c;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0);
        bus2.set_req = 1'b0;
        bus2.clr_req = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL reset_hold: got %b want 00000", obs);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 0", bus.req_ready);
        end
        @(negedge clk);
        checks++;
        if (obs !== 5'b10000) begin
            errors++;
            $display("FAIL reset_first_edge: got %b want 10000", obs);
        end
        m_acc = n - 1000;
    endtask

    task automatic test_set();
        logic [4:0] e;
        drive(1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            model_edge(e);
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL set k=%0d: got %b want %b", k, obs, e);
            end
            if (k == 0) drive(1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        drive(1'b1, 1'b0);
        for (int k = 0; k < 11; k++) begin
            @(posedge clk);
            model_edge(e);
            @(negedge clk);
            checks++;
            if (obs !== e || (bus.S & bus.R)) begin
                errors++;
                $display("FAIL back_to_back k=%0d: got %b want %b", k, obs, e);
            end
            if (k == 0) drive(1'b0, 1'b1);
            if (k == 5) drive(1'b0, 1'b0);
        end
    endtask

    task automatic test_conflict();
        logic [4:0] e;
        drive(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            model_edge(e);
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL conflict k=%0d: got %b want %b", k, obs, e);
            end
            if (k == 0) drive(1'b0, 1'b0);
        end
    endtask

    task automatic test_random();
        logic [4:0] e;
        int r;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 7));
            drive(r == 4 || r == 5 || r == 7, r == 6 || r == 7);
            @(posedge clk);
            model_edge(e);
            @(negedge clk);
            checks++;
            if (obs !== e || (bus.S & bus.R)) begin
                errors++;
                $display("FAIL random i=%0d: got %b want %b", i, obs, e);
            end
        end
        drive(1'b0, 1'b0);
        for (int k = 0; k < L + 1; k++) begin
            @(posedge clk);
            model_edge(e);
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL random_drain k=%0d: got %b want %b", k, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [4:0] e;
        drive(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            model_edge(e);
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mid_pulse_pre k=%0d: got %b want %b", k, obs, e);
            end
            if (k == 0) drive(1'b0, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL mid_pulse_async: got %b want 00000", obs);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL mid_pulse_hold k=%0d: got %b want 00000", k, obs);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 5'b10000) begin
            errors++;
            $display("FAIL mid_pulse_release: got %b want 10000", obs);
        end
        m_acc = n - 1000;
    endtask

    task automatic test_long();
        int done_j = -1, first_s = -1, s_cnt = 0, r_cnt = 0, early_rdy = 0, err_cnt = 0;
        bus2.set_req = 1'b1;
        for (int j = 0; j < 40 && done_j < 0; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == 0) bus2.set_req = 1'b0;
            if (bus2.S) begin
                s_cnt++;
                if (first_s < 0) first_s = j;
            end
            if (bus2.R) r_cnt++;
            if (bus2.err) err_cnt++;
            if (bus2.done) done_j = j;
            else if (bus2.req_ready) early_rdy++;
        end
        checks++;
        if (done_j != 31) begin
            errors++;
            $display("FAIL long_latency: got %0d want 31", done_j);
        end
        checks++;
        if (first_s != 15 || s_cnt != 15) begin
            errors++;
            $display("FAIL long_pulse: first %0d len %0d want first 15 len 15", first_s, s_cnt);
        end
        checks++;
        if (r_cnt != 0 || early_rdy != 0 || err_cnt != 0) begin
            errors++;
            $display("FAIL long_quiet: R %0d ready %0d err %0d want 0 0 0", r_cnt, early_rdy, err_cnt);
        end
    endtask

`ifdef SR_PULSE_VERIFY_EN
    task automatic test_verify();
        int done_k, err_k, err_cnt;
        for (int pass = 0; pass < 2; pass++) begin
            fb_sel  = (pass == 1);
            fb_force = 1'b0;
            done_k  = -1;
            err_k   = -1;
            err_cnt = 0;
            drive(1'b1, 1'b0);
            for (int k = 0; k < 7; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (k == 0) drive(1'b0, 1'b0);
                if (bus.done) done_k = k;
                if (bus.err) begin
                    err_k = k;
                    err_cnt++;
                end
            end
            checks++;
            if (done_k != L) begin
                errors++;
                $display("FAIL verify_done pass=%0d: got %0d want %0d", pass, done_k, L);
            end
            checks++;
            if (pass == 0 && (err_k != L || err_cnt != 1)) begin
                errors++;
                $display("FAIL verify_err_tied0: at %0d count %0d want %0d count 1", err_k, err_cnt, L);
            end else if (pass == 1 && err_cnt != 0) begin
                errors++;
                $display("FAIL verify_err_latch: count %0d want 0", err_cnt);
            end
        end
        fb_sel = 1'b1;
        m_acc  = n - 1000;
    endtask
`endif

    initial begin
        test_reset();
        test_set();
        test_back_to_back();
        test_conflict();
        test_random();
`ifdef SR_PULSE_VERIFY_EN
        test_verify();
`endif
        test_long();
        test_reset_mid_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sr_pulse_driver.md
SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

Interface
REQ-001 The block SHALL have parameter PULSE_W, default 2, meaning S/R pulse width in clock cycles, legal range 1..15.
REQ-002 The block SHALL have parameter GAP_W, default 1, meaning the minimum all-low guard cycles before every pulse, legal range 1..15.
REQ-003 clk  input  1  rising-edge system clock, the only clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 set_req  input  1  request to set the latch (Q=1).
REQ-006 clr_req  input  1  request to clear the latch (Q=0).
REQ-007 req_ready  output  1  high when a request is accepted this cycle.
REQ-008 S  output  1  set drive to the downstream NOR SR latch.
REQ-009 R  output  1  reset drive to the downstream NOR SR latch.
REQ-010 q_fb  input  1  latch Q fed back, asynchronous to clk.
REQ-011 done  output  1  one-cycle pulse when a command completes.
REQ-012 err  output  1  one-cycle pulse on a rejected request or a failed feedback check.

Function
REQ-013 The block SHALL implement FSM states IDLE, GAP, PULSE and CHECK, and SHALL encode no other state.
REQ-014 req_ready SHALL be high only in IDLE; a request is accepted when req_ready=1 and exactly one of set_req or clr_req is 1.
REQ-015 On acceptance, the block SHALL latch the command (set=1 or clr=0) and go IDLE->GAP.
REQ-016 If set_req=1 and clr_req=1 in IDLE, the block SHALL accept nothing, pulse err for 1 cycle the next cycle, and stay in IDLE.
REQ-017 GAP SHALL hold S=0 and R=0 for exactly GAP_W cycles, then go to PULSE.
REQ-018 PULSE SHALL drive S=1 (set command) or R=1 (clr command) for exactly PULSE_W cycles, then go to CHECK.
REQ-019 S and R SHALL be registered outputs and SHALL never be 1 in the same cycle, including across state transitions.
REQ-020 CHECK SHALL last 1 cycle with S=R=0, then return to IDLE and pulse done=1 in that cycle.
REQ-021 Requests asserted outside IDLE SHALL be ignored and neither queued nor flagged; the requester holds them until req_ready.
REQ-022 Latency from the accept edge to the done pulse SHALL be GAP_W+PULSE_W+1 cycles; minimum back-to-back spacing is the same.
REQ-023 The PULSE_W and GAP_W counters SHALL be 4 bits, count down to 0, and never wrap.

Reset
REQ-024 While rst_n=0, the block SHALL force state=IDLE, S=0, R=0, done=0, err=0, req_ready=0, with all counters 0 and the synchronizer cleared.
REQ-025 Reset asserted mid-PULSE SHALL drop S/R to 0 immediately (asynchronously) and SHALL produce no done or err.
REQ-026 req_ready SHALL go to 1 at the first clk edge after rst_n deasserts.

Configuration
REQ-027 Macro SR_PULSE_VERIFY_EN SHALL control the feedback check.
REQ-028 With SR_PULSE_VERIFY_EN defined: q_fb passes through a 2-flop synchronizer; in CHECK, a synchronized q_fb that differs from the command SHALL pulse err together with done.
REQ-029 Without SR_PULSE_VERIFY_EN: q_fb is unused, no synchronizer is built, and err pulses only per REQ-016.

Verification
REQ-030 Reset release, then set_req=1 for 1 cycle -> req_ready low 4 cycles; S=0 1 cycle, S=1 2 cycles, done at accept+4; R stays 0.
REQ-031 clr_req=1 held through busy after a set -> second command accepted on the first IDLE cycle; R pulses 2 cycles; no S/R overlap anywhere.
REQ-032 set_req=1 and clr_req=1 in IDLE -> err 1 cycle, S=R=0, req_ready stays 1.
REQ-033 rst_n=0 on the 2nd PULSE cycle -> S=0 asynchronously, no done or err; after release, IDLE with req_ready=1.
REQ-034 SR_PULSE_VERIFY_EN defined, q_fb tied 0, set command -> err and done both 1 in the same cycle; a real latch model on S/R -> err stays 0.
REQ-035 PULSE_W=15, GAP_W=15 -> done exactly 31 cycles after accept; counters do not wrap.
